// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation and
// mid-bit data sampling (LSB first), with one-cycle valid / frame_err strobes.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    // A start bit that is no longer low at mid-bit is treated as a glitch.
                    if (cnt_q == HALF_LAST) begin
                        if (!rx_s) begin
                            state_q   <= DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        shift_q[bit_idx_q] <= rx_s;
                        cnt_q              <= '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BRK: begin
                    // Hold off until the line returns high so a long break is not a new start.
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
